// File: rtl/mouse_receiver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mouse_receiver
// Description : Receives one PS/2 device-to-host frame (start bit, 8 data bits
//               LSB first, odd parity bit, stop bit) by passively sampling the
//               PS/2 clock and data lines. When a frame completes, it presents
//               the data byte and its error flags to the mouse master FSM.
// Ports       :
//   CLK              system clock (50 MHz nominal)
//   RESET            asynchronous active-high reset
//   CLK_MOUSE_IN     PS/2 clock line (asynchronous)
//   DATA_MOUSE_IN    PS/2 data line (asynchronous)
//   READ_ENABLE      a new frame may start only while this is high
//   BYTE             last received data byte
//   BYTE_ERROR_CODE  [0] parity error, [1] stop-bit error
//   BYTE_READ        one-cycle strobe; BYTE and BYTE_ERROR_CODE were updated
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module mouse_receiver #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READ
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  // Two-flop synchronisers; reset to 1 to match an idle bus.
  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;

  logic [2:0]  state_q,    state_d;
  logic [2:0]  bit_cnt_q,  bit_cnt_d;
  logic [7:0]  shreg_q,    shreg_d;
  logic        par_err_q,  par_err_d;
  logic        stop_err_q, stop_err_d;
  logic [15:0] to_cnt_q,   to_cnt_d;
  logic [7:0]  byte_q,     byte_d;
  logic [1:0]  err_q,      err_d;
  logic        byte_read_q, byte_read_d;

  logic fall;
  logic bit_in;
  logic timeout;

  assign fall    = clk_prev_q & ~clk_s2_q;
  assign bit_in  = dat_s2_q;
  // A fall in the same cycle always takes priority over the timeout.
  assign timeout = (to_cnt_q == TO_LAST) & ~fall;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    par_err_d   = par_err_q;
    stop_err_d  = stop_err_q;
    byte_d      = byte_q;
    err_d       = err_q;
    byte_read_d = 1'b0;

    if ((state_q == S_IDLE) || fall) begin
      to_cnt_d = 16'd0;
    end else begin
      to_cnt_d = to_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        // Start bit is a low data line at the fall; anything else is ignored.
        if (fall && READ_ENABLE && !bit_in) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shreg_d   = {bit_in, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_PARITY: begin
        if (fall) begin
          // Odd parity: data ones plus parity bit must be odd.
          par_err_d = ~(bit_in ^ (^shreg_q));
          state_d   = S_STOP;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_STOP: begin
        if (fall) begin
          stop_err_d = ~bit_in;
          state_d    = S_DONE;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        byte_d      = shreg_q;
        err_d       = {stop_err_q, par_err_q};
        byte_read_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_prev_q  <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'h00;
      par_err_q   <= 1'b0;
      stop_err_q  <= 1'b0;
      to_cnt_q    <= 16'd0;
      byte_q      <= 8'h00;
      err_q       <= 2'b00;
      byte_read_q <= 1'b0;
    end else begin
      clk_s1_q    <= CLK_MOUSE_IN;
      clk_s2_q    <= clk_s1_q;
      clk_prev_q  <= clk_s2_q;
      dat_s1_q    <= DATA_MOUSE_IN;
      dat_s2_q    <= dat_s1_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_err_q   <= par_err_d;
      stop_err_q  <= stop_err_d;
      to_cnt_q    <= to_cnt_d;
      byte_q      <= byte_d;
      err_q       <= err_d;
      byte_read_q <= byte_read_d;
    end
  end

  assign BYTE            = byte_q;
  assign BYTE_ERROR_CODE = err_q;
  assign BYTE_READ       = byte_read_q;

endmodule
`default_nettype wire

// File: tb/tb_mouse_receiver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_mouse_receiver
// Description : Self-checking bench for mouse_receiver. PS/2 timing is scaled
//               down (short bit period and timeout) to keep runs short; the
//               ratios between bit period, timeout and idle gaps are preserved.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mouse_receiver;

  localparam int TO   = 200;  // timeout in CLK cycles
  localparam int HALF = 40;   // PS/2 half period in CLK cycles (period 80 < TO)

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       rd_en;
  logic [7:0] byte_o;
  logic [1:0] err_o;
  logic       br_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] b;
    logic [1:0] e;
    int         c;
  } exp_t;

  exp_t q[$];

  mouse_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK             (clk),
    .RESET           (rst),
    .CLK_MOUSE_IN    (ps2_clk),
    .DATA_MOUSE_IN   (ps2_dat),
    .READ_ENABLE     (rd_en),
    .BYTE            (byte_o),
    .BYTE_ERROR_CODE (err_o),
    .BYTE_READ       (br_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest queued frame.
  logic prev_br = 1'b0;
  always @(posedge clk) begin
    #1;
    if (prev_br) chk("br_width", 32'(br_o), 0);
    if (br_o === 1'b1) begin
      chk("pulse_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("byte", 32'(byte_o), 32'(e.b));
        chk("err", 32'(err_o), 32'(e.e));
        chk("latency", 32'(cyc - e.c), 4);
      end
    end
    prev_br = br_o;
  end

  // Sends the first nbits of a frame (11 = complete frame).
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int nbits, input bit expect_out);
    logic [10:0] bits;
    bits = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_dat = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && expect_out) begin
        exp_t e;
        e.b = b;
        e.e = {~stp, ~(^b ^ par)};
        e.c = cyc;
        q.push_back(e);
      end
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_dat = 1'b1;
  endtask

  task automatic settle(input string tag, input logic [7:0] hold_byte);
    repeat (20) @(negedge clk);
    chk({tag, "_drain"}, 32'(q.size()), 0);
    chk({tag, "_hold"}, 32'(byte_o), 32'(hold_byte));
  endtask

  initial begin
    rst     = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    rd_en   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_byte", 32'(byte_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_br", 32'(br_o), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Normal acknowledge byte.
    send_frame(8'hFA, 1'b1, 1'b1, 11, 1'b1);
    settle("ack", 8'hFA);

    // Parity error.
    send_frame(8'hAA, 1'b0, 1'b1, 11, 1'b1);
    settle("par", 8'hAA);

    // Stop-bit error.
    send_frame(8'h00, 1'b1, 1'b0, 11, 1'b1);
    settle("stop", 8'h00);

    // Timeout: start + 4 data bits, then idle well past the timeout.
    send_frame(8'hFF, 1'b1, 1'b1, 5, 1'b0);
    repeat (TO + 100) @(negedge clk);
    send_frame(8'h08, 1'b0, 1'b1, 11, 1'b1);
    settle("tmo", 8'h08);

    // READ_ENABLE low blocks the whole frame.
    rd_en = 1'b0;
    send_frame(8'h55, 1'b1, 1'b1, 11, 1'b0);
    settle("gate", 8'h08);
    rd_en = 1'b1;
    send_frame(8'h55, 1'b1, 1'b1, 11, 1'b1);
    settle("ungate", 8'h55);

    // Reset after 3 data bits.
    send_frame(8'h33, 1'b1, 1'b1, 4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_byte", 32'(byte_o), 0);
    chk("mid_rst_err", 32'(err_o), 0);
    chk("mid_rst_br", 32'(br_o), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'hFA, 1'b1, 1'b1, 11, 1'b1);
    settle("post_rst", 8'hFA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
